ps2_event_rx: RTL and testbench
===============================

// Module: ps2_event_rx
// PURPOSE
//  Next-generation PS/2 keyboard receiver, fully synchronous to the system clock (no kclk-edge logic).
//  Samples ps2_clk/ps2_data, glitch-filters them, and frames 11-bit packets with parity, stop-bit and timeout checks.
//  Folds E0/F0 prefixes into key events {ext,brk,code} and buffers them in a FIFO with a valid/ready port.
//  Sits between the board PS/2 pins and the game logic, which maps codes to player actions.
// PARAMETERS
//  CLK_HZ      100_000_000  system clock frequency, Hz
//  FILT_LEN    8            consecutive equal samples before a filtered line changes level (>=2)
//  TIMEOUT_US  2000         max gap between ps2_clk falling edges inside a frame, us
//  FIFO_DEPTH  8            event FIFO entries; power of two, >=2
// PORTS
//  clk         in   1   system clock
//  rst_n       in   1   asynchronous active-low reset
//  ps2_clk     in   1   raw keyboard clock (async)
//  ps2_data    in   1   raw keyboard data (async)
//  ev_valid    out  1   FIFO head holds an event
//  ev_ready    in   1   consumer accepts head this cycle
//  ev_code     out  8   head scan code (prefixes stripped)
//  ev_brk      out  1   head is a release (F0-prefixed)
//  ev_ext      out  1   head is extended (E0-prefixed)
//  err_parity  out  1   one-cycle pulse: parity failure
//  err_frame   out  1   one-cycle pulse: bad start/stop bit or timeout
//  err_cnt     out  8   saturating count of all errors
//  overflow    out  1   sticky: an event was dropped on a full FIFO
// BEHAVIOUR
//  Reset: every output 0, FIFO empty, FSM IDLE, prefixes cleared, filtered lines 1. Reset mid-frame discards the frame.
//  Input path: 2-FF synchroniser per line, then a FILT_LEN filter. Edge strobe = filtered ps2_clk 1->0, 1 cycle.
//  TMO = CLK_HZ/1_000_000*TIMEOUT_US cycles. Gap counter clears on every strobe and runs only outside IDLE.
//  FSM, advances on strobe only:
//   IDLE:  data=0 -> DATA, bitcnt=0. data=1 -> stay IDLE, pulse err_frame.
//   DATA:  shift data into bit[bitcnt], LSB first. After bit 7 -> PARITY.
//   PARITY: latch parity bit -> STOP.
//   STOP:  stop=1 and odd parity over 9 bits -> byte strobe. Parity bad -> err_parity.
//          Parity ok but stop=0 -> err_frame. Any outcome -> IDLE.
//   Any non-IDLE state with gap counter = TMO -> IDLE, pulse err_frame; partial byte discarded.
//  err_cnt: +1 per error pulse, saturates at 255. Any error clears the E0/F0 pending flags.
//  Decoder, registered, acts on byte strobe:
//   E0 -> set ext_pend. F0 -> set brk_pend. Any other byte (incl. E1, AA, FA) -> event {ext_pend,brk_pend,byte}, clear both.
//  Latency: ev_valid on an empty FIFO rises exactly 2 clk cycles after the stop-bit strobe.
//  FIFO: entries are 10 bits. ev_* show the head. ev_valid = (count != 0).
//   Pop when ev_valid && ev_ready. ev_ready with ev_valid=0 is ignored.
//   Push on full without a same-cycle pop -> event dropped, overflow=1 until reset.
//   Push and pop in the same cycle when full -> both happen, no overflow.
//   Push and pop in the same cycle when empty -> push only.
//   Pointers are log2(FIFO_DEPTH) bits and wrap naturally. count is log2(FIFO_DEPTH)+1 bits.
// CONFIGURATION
//  TYPEMATIC_FILTER_EN defined: holds last_make {ext,code}, cleared at reset.
//   A make equal to last_make is not pushed; any other make is pushed and updates last_make.
//   A break matching last_make is pushed and clears last_make. Other breaks are pushed unchanged.
//  Undefined: every decoded event is pushed, auto-repeat makes included. No last_make register is built.
// TESTING
//  1 Reset; frame 0x1D, correct parity, 3-cycle glitch on ps2_clk mid-bit -> one event code=1D ext=0 brk=0,
//    ev_valid 2 cycles after stop strobe, err_cnt=0.
//  2 Bytes F0,1D then E0,F0,75 -> events {0,1,1D} then {1,1,75}; no events for prefixes.
//  3 Frame 0x1C with parity flipped -> err_parity pulse, err_cnt=1, no event; next good 0x1C -> event 1C.
//  4 Stop after 4 data bits, idle > TMO -> err_frame pulse, err_cnt=1; following 0x23 frame -> event 23.
//  5 ev_ready=0; push 9 makes 0x16..0x1E (DEPTH=8) -> overflow=1; drain returns 0x16..0x1D in order, then ev_valid=0.
//  6 Makes 1D,1D,1D then F0,1D -> with TYPEMATIC_FILTER_EN: 2 events (1D make, 1D break); without: 4 events.

Source files
------------

// File: rtl/ps2_event_rx_if.sv
// rtl/ps2_event_rx_if.sv - key event valid/ready stream between ps2_event_rx and its consumer
interface ps2_event_rx_if;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic       ev_brk;
    logic       ev_ext;

    modport master (output ev_valid, output ev_code, output ev_brk, output ev_ext, input ev_ready);
    modport slave  (input ev_valid, input ev_code, input ev_brk, input ev_ext, output ev_ready);
endinterface

// File: rtl/ps2_event_rx.sv
// rtl/ps2_event_rx.sv - PS/2 keyboard receiver: filter, framer, E0/F0 decoder, event FIFO
// Optional auto-repeat suppression is built when TYPEMATIC_FILTER_EN is defined.
module ps2_event_rx #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int FILT_LEN   = 8,
    parameter int TIMEOUT_US = 2000,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ps2_clk,
    input  logic              ps2_data,
    ps2_event_rx_if.master    ev,
    output logic              err_parity,
    output logic              err_frame,
    output logic [7:0]        err_cnt,
    output logic              overflow
);
    localparam int TMO   = CLK_HZ / 1_000_000 * TIMEOUT_US;
    localparam int GAP_W = $clog2(TMO + 1);
    localparam int FW    = $clog2(FILT_LEN);
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int CW    = PW + 1;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic [1:0]       sync_clk_q, sync_clk_d, sync_dat_q, sync_dat_d;
    logic             fclk_q, fclk_d, fdat_q, fdat_d, fclk_prev_q, fclk_prev_d;
    logic [FW-1:0]    fclk_cnt_q, fclk_cnt_d, fdat_cnt_q, fdat_cnt_d;
    logic             clk_fall;
    state_t           state_q, state_d;
    logic [2:0]       bitcnt_q, bitcnt_d;
    logic [7:0]       shreg_q, shreg_d, byte_q, byte_d;
    logic             par_q, par_d, byte_stb_q, byte_stb_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             err_par_q, err_par_d, err_frm_q, err_frm_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic             ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;
    logic             push, pop, full, wr_ok;
    logic [9:0]       ev_word;
    logic [9:0]       mem_q [FIFO_DEPTH];
    logic [9:0]       mem_d [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
`ifdef TYPEMATIC_FILTER_EN
    logic [8:0]       last_make_q, last_make_d;
`endif

    assign clk_fall = fclk_prev_q & ~fclk_q;

    // Synchroniser and run-length filter: a line only moves after FILT_LEN disagreeing samples.
    always_comb begin
        sync_clk_d  = {sync_clk_q[0], ps2_clk};
        sync_dat_d  = {sync_dat_q[0], ps2_data};
        fclk_prev_d = fclk_q;
        fclk_d      = fclk_q;
        fclk_cnt_d  = '0;
        fdat_d      = fdat_q;
        fdat_cnt_d  = '0;
        if (sync_clk_q[1] != fclk_q) begin
            if (fclk_cnt_q == FW'(FILT_LEN - 1)) fclk_d = sync_clk_q[1];
            else                                 fclk_cnt_d = fclk_cnt_q + 1'b1;
        end
        if (sync_dat_q[1] != fdat_q) begin
            if (fdat_cnt_q == FW'(FILT_LEN - 1)) fdat_d = sync_dat_q[1];
            else                                 fdat_cnt_d = fdat_cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shreg_d    = shreg_q;
        par_d      = par_q;
        byte_d     = byte_q;
        byte_stb_d = 1'b0;
        err_par_d  = 1'b0;
        err_frm_d  = 1'b0;
        if (state_q == S_IDLE || clk_fall) gap_d = '0;
        else if (gap_q == GAP_W'(TMO))     gap_d = gap_q;
        else                               gap_d = gap_q + 1'b1;
        if (clk_fall) begin
            case (state_q)
                S_IDLE: begin
                    if (!fdat_q) begin
                        state_d  = S_DATA;
                        bitcnt_d = '0;
                    end else begin
                        err_frm_d = 1'b1;
                    end
                end
                S_DATA: begin
                    shreg_d[bitcnt_q] = fdat_q;
                    if (bitcnt_q == 3'd7) state_d = S_PARITY;
                    else                  bitcnt_d = bitcnt_q + 1'b1;
                end
                S_PARITY: begin
                    par_d   = fdat_q;
                    state_d = S_STOP;
                end
                default: begin
                    state_d = S_IDLE;
                    if (!(^{shreg_q, par_q})) begin
                        err_par_d = 1'b1;
                    end else if (!fdat_q) begin
                        err_frm_d = 1'b1;
                    end else begin
                        byte_stb_d = 1'b1;
                        byte_d     = shreg_q;
                    end
                end
            endcase
        end else if (state_q != S_IDLE && gap_q == GAP_W'(TMO)) begin
            state_d   = S_IDLE;
            err_frm_d = 1'b1;
        end
        err_cnt_d = err_cnt_q;
        if ((err_par_d || err_frm_d) && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 1'b1;
    end

    // Prefix folding; the event is pushed in the cycle after the byte strobe.
    always_comb begin
        ext_pend_d = ext_pend_q;
        brk_pend_d = brk_pend_q;
        push       = 1'b0;
        ev_word    = {ext_pend_q, brk_pend_q, byte_q};
`ifdef TYPEMATIC_FILTER_EN
        last_make_d = last_make_q;
`endif
        if (err_par_q || err_frm_q) begin
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
        end else if (byte_stb_q) begin
            if (byte_q == 8'hE0) begin
                ext_pend_d = 1'b1;
            end else if (byte_q == 8'hF0) begin
                brk_pend_d = 1'b1;
            end else begin
                push       = 1'b1;
                ext_pend_d = 1'b0;
                brk_pend_d = 1'b0;
`ifdef TYPEMATIC_FILTER_EN
                if (!brk_pend_q) begin
                    if ({ext_pend_q, byte_q} == last_make_q) push = 1'b0;
                    else                                     last_make_d = {ext_pend_q, byte_q};
                end else if ({ext_pend_q, byte_q} == last_make_q) begin
                    last_make_d = '0;
                end
`endif
            end
        end
    end

    always_comb begin
        pop        = (count_q != '0) && ev.ev_ready;
        full       = (count_q == CW'(FIFO_DEPTH));
        wr_ok      = push && (!full || pop);
        overflow_d = overflow_q | (push && full && !pop);
        mem_d      = mem_q;
        if (wr_ok) mem_d[wr_ptr_q] = ev_word;
        wr_ptr_d   = wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q;
        if (wr_ok && !pop)      count_d = count_q + 1'b1;
        else if (!wr_ok && pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_clk_q  <= 2'b11;
            sync_dat_q  <= 2'b11;
            fclk_q      <= 1'b1;
            fdat_q      <= 1'b1;
            fclk_prev_q <= 1'b1;
            fclk_cnt_q  <= '0;
            fdat_cnt_q  <= '0;
            state_q     <= S_IDLE;
            bitcnt_q    <= '0;
            shreg_q     <= '0;
            par_q       <= 1'b0;
            byte_q      <= '0;
            byte_stb_q  <= 1'b0;
            gap_q       <= '0;
            err_par_q   <= 1'b0;
            err_frm_q   <= 1'b0;
            err_cnt_q   <= '0;
            ext_pend_q  <= 1'b0;
            brk_pend_q  <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
`ifdef TYPEMATIC_FILTER_EN
            last_make_q <= '0;
`endif
        end else begin
            sync_clk_q  <= sync_clk_d;
            sync_dat_q  <= sync_dat_d;
            fclk_q      <= fclk_d;
            fdat_q      <= fdat_d;
            fclk_prev_q <= fclk_prev_d;
            fclk_cnt_q  <= fclk_cnt_d;
            fdat_cnt_q  <= fdat_cnt_d;
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shreg_q     <= shreg_d;
            par_q       <= par_d;
            byte_q      <= byte_d;
            byte_stb_q  <= byte_stb_d;
            gap_q       <= gap_d;
            err_par_q   <= err_par_d;
            err_frm_q   <= err_frm_d;
            err_cnt_q   <= err_cnt_d;
            ext_pend_q  <= ext_pend_d;
            brk_pend_q  <= brk_pend_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
`ifdef TYPEMATIC_FILTER_EN
            last_make_q <= last_make_d;
`endif
        end
    end

    assign ev.ev_valid = (count_q != '0);
    assign {ev.ev_ext, ev.ev_brk, ev.ev_code} = mem_q[rd_ptr_q];
    assign err_parity  = err_par_q;
    assign err_frame   = err_frm_q;
    assign err_cnt     = err_cnt_q;
    assign overflow    = overflow_q;
endmodule

// File: tb/tb_ps2_event_rx.sv
// tb/tb_ps2_event_rx.sv - self-checking bench for ps2_event_rx against a queue-based key event model
module tb_ps2_event_rx;
    localparam int CLK_HZ     = 1_000_000;
    localparam int TIMEOUT_US = 200;
    localparam int FILT_LEN   = 8;
    localparam int FIFO_DEPTH = 8;

    logic       clk, rst_n, ps2_clk, ps2_data;
    logic       err_parity, err_frame, overflow;
    logic [7:0] err_cnt;
    int         n_checks, n_errors;
    int         cyc, strobe_cyc, rise_cyc, par_pulses, frm_pulses;
    logic       prev_valid;

    logic [9:0] exp_q[$];
    logic [9:0] obs_q[$];
    logic       m_ext, m_brk, m_ovf;
    logic [8:0] m_last;
    int         m_errs;

    ps2_event_rx_if evif();

    ps2_event_rx #(.CLK_HZ(CLK_HZ), .FILT_LEN(FILT_LEN), .TIMEOUT_US(TIMEOUT_US),
                   .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .ev(evif),
        .err_parity(err_parity), .err_frame(err_frame), .err_cnt(err_cnt), .overflow(overflow));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dut.clk_fall) strobe_cyc = cyc;
        if (evif.ev_valid && !prev_valid) rise_cyc = cyc;
        prev_valid = evif.ev_valid;
        if (err_parity) par_pulses++;
        if (err_frame)  frm_pulses++;
    end

    // Key event model: prefixes fold into the next ordinary byte; FIFO drops when holding DEPTH events.
    task automatic model_push(input logic [9:0] e);
        if (exp_q.size() == FIFO_DEPTH) m_ovf = 1'b1;
        else                            exp_q.push_back(e);
    endtask

    task automatic model_byte(input logic [7:0] b);
        bit keep;
        if (b == 8'hE0)      m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            keep = 1'b1;
`ifdef TYPEMATIC_FILTER_EN
            if (!m_brk) begin
                if ({m_ext, b} == m_last) keep = 1'b0;
                else                      m_last = {m_ext, b};
            end else if ({m_ext, b} == m_last) begin
                m_last = '0;
            end
`endif
            if (keep) model_push({m_ext, m_brk, b});
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic model_err();
        m_ext = 1'b0;
        m_brk = 1'b0;
        if (m_errs < 255) m_errs++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        evif.ev_ready = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        m_ext = 0; m_brk = 0; m_ovf = 0; m_last = '0; m_errs = 0;
        repeat (2) @(negedge clk);
        par_pulses = 0;
        frm_pulses = 0;
    endtask

    task automatic send_bit(input logic d, input bit glitch);
        ps2_data = d;
        if (glitch) begin
            repeat (3) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (3) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (4) @(negedge clk);
        end else begin
            repeat (10) @(negedge clk);
        end
        ps2_clk = 1'b0;
        repeat (20) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit flip_par, input bit glitch);
        logic [10:0] bits;
        bits = {1'b1, (~^b) ^ flip_par, b, 1'b0};
        for (int i = 0; i < 11; i++) send_bit(bits[i], glitch && i == 4);
        ps2_data = 1'b1;
        repeat (40) @(negedge clk);
    endtask

    task automatic send_partial(input int n_data);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < n_data; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
        ps2_data = 1'b1;
    endtask

    task automatic drain();
        obs_q.delete();
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            if (!evif.ev_valid) break;
            obs_q.push_back({evif.ev_ext, evif.ev_brk, evif.ev_code});
            evif.ev_ready = 1'b1;
            @(negedge clk);
        end
        evif.ev_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({evif.ev_valid, err_parity, err_frame, overflow} !== 4'b0 || err_cnt !== 8'h00 ||
            {evif.ev_ext, evif.ev_brk, evif.ev_code} !== 10'h0) begin
            $display("FAIL reset_outputs: valid=%b perr=%b ferr=%b ovf=%b cnt=%0d head=%h, want all 0",
                     evif.ev_valid, err_parity, err_frame, overflow, err_cnt,
                     {evif.ev_ext, evif.ev_brk, evif.ev_code});
            n_errors++;
        end
        send_partial(3);
        do_reset();
        send_frame(8'h2A, 1'b0, 1'b0);
        model_byte(8'h2A);
        drain();
        n_checks++;
        if (obs_q.size() != 1 || obs_q[0] !== 10'h02A || err_cnt !== 8'd0) begin
            $display("FAIL reset_midframe: events=%0d first=%h errcnt=%0d, want 1 event 02A errcnt 0",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 10'h3FF, err_cnt);
            n_errors++;
        end
    endtask

    task automatic test_glitch_latency();
        do_reset();
        send_frame(8'h1D, 1'b0, 1'b1);
        n_checks++;
        if (rise_cyc - strobe_cyc != 2) begin
            $display("FAIL latency: got %0d cycles, want 2", rise_cyc - strobe_cyc);
            n_errors++;
        end
        model_byte(8'h1D);
        drain();
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            $display("FAIL glitch_count: got %0d events, want %0d", obs_q.size(), exp_q.size());
            n_errors++;
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                $display("FAIL glitch_event[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
                n_errors++;
            end
        end
        n_checks++;
        if (err_cnt !== 8'd0 || frm_pulses != 0) begin
            $display("FAIL glitch_errs: errcnt=%0d frame_pulses=%0d, want 0 0", err_cnt, frm_pulses);
            n_errors++;
        end
    endtask

    task automatic test_prefixes();
        logic [7:0] seq [5];
        seq = '{8'hF0, 8'h1D, 8'hE0, 8'hF0, 8'h75};
        do_reset();
        foreach (seq[i]) begin
            send_frame(seq[i], 1'b0, 1'b0);
            model_byte(seq[i]);
        end
        drain();
        n_checks++;
        if (obs_q.size() != 2 || obs_q.size() != exp_q.size()) begin
            $display("FAIL prefix_count: got %0d events, want 2 (model %0d)", obs_q.size(), exp_q.size());
            n_errors++;
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                $display("FAIL prefix_event[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
                n_errors++;
            end
        end
    endtask

    task automatic test_parity();
        do_reset();
        send_frame(8'h1C, 1'b1, 1'b0);
        model_err();
        n_checks++;
        if (par_pulses != 1 || frm_pulses != 0 || err_cnt !== 8'(m_errs) || evif.ev_valid !== 1'b0) begin
            $display("FAIL parity_err: ppulses=%0d fpulses=%0d errcnt=%0d valid=%b, want 1 0 %0d 0",
                     par_pulses, frm_pulses, err_cnt, evif.ev_valid, m_errs);
            n_errors++;
        end
        send_frame(8'h1C, 1'b0, 1'b0);
        model_byte(8'h1C);
        drain();
        n_checks++;
        if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
            $display("FAIL parity_recover: events=%0d first=%h, want 1 event %h",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 10'h3FF, exp_q[0]);
            n_errors++;
        end
    endtask

    task automatic test_timeout();
        do_reset();
        send_partial(4);
        repeat (260) @(negedge clk);
        model_err();
        n_checks++;
        if (frm_pulses != 1 || par_pulses != 0 || err_cnt !== 8'(m_errs)) begin
            $display("FAIL timeout_err: fpulses=%0d ppulses=%0d errcnt=%0d, want 1 0 %0d",
                     frm_pulses, par_pulses, err_cnt, m_errs);
            n_errors++;
        end
        send_frame(8'h23, 1'b0, 1'b0);
        model_byte(8'h23);
        drain();
        n_checks++;
        if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
            $display("FAIL timeout_recover: events=%0d first=%h, want 1 event %h",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 10'h3FF, exp_q[0]);
            n_errors++;
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            send_frame(8'h16 + 8'(i), 1'b0, 1'b0);
            model_byte(8'h16 + 8'(i));
        end
        n_checks++;
        if (overflow !== m_ovf || overflow !== 1'b1) begin
            $display("FAIL overflow_flag: got %b want %b", overflow, m_ovf);
            n_errors++;
        end
        drain();
        n_checks++;
        if (obs_q.size() != FIFO_DEPTH || obs_q.size() != exp_q.size()) begin
            $display("FAIL overflow_count: got %0d events, want %0d", obs_q.size(), FIFO_DEPTH);
            n_errors++;
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                $display("FAIL overflow_event[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
                n_errors++;
            end
        end
        n_checks++;
        if (evif.ev_valid !== 1'b0 || overflow !== 1'b1) begin
            $display("FAIL overflow_after_drain: valid=%b ovf=%b, want 0 1", evif.ev_valid, overflow);
            n_errors++;
        end
    endtask

    task automatic test_typematic();
        logic [7:0] seq [5];
        int         want;
        seq = '{8'h1D, 8'h1D, 8'h1D, 8'hF0, 8'h1D};
`ifdef TYPEMATIC_FILTER_EN
        want = 2;
`else
        want = 4;
`endif
        do_reset();
        foreach (seq[i]) begin
            send_frame(seq[i], 1'b0, 1'b0);
            model_byte(seq[i]);
        end
        drain();
        n_checks++;
        if (obs_q.size() != want || obs_q.size() != exp_q.size()) begin
            $display("FAIL typematic_count: got %0d events, want %0d", obs_q.size(), want);
            n_errors++;
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                $display("FAIL typematic_event[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
                n_errors++;
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        bit         flip;
        do_reset();
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 6; k++) begin
                case ($urandom_range(0, 9))
                    0:       b = 8'hE0;
                    1:       b = 8'hF0;
                    default: b = 8'($urandom_range(1, 255));
                endcase
                flip = ($urandom_range(0, 7) == 0);
                send_frame(b, flip, 1'b0);
                if (flip) model_err();
                else      model_byte(b);
            end
            drain();
            n_checks++;
            if (obs_q.size() != exp_q.size() || err_cnt !== 8'(m_errs) || overflow !== m_ovf) begin
                $display("FAIL random_round%0d: events=%0d errcnt=%0d ovf=%b, want %0d %0d %b",
                         r, obs_q.size(), err_cnt, overflow, exp_q.size(), m_errs, m_ovf);
                n_errors++;
            end
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                n_checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    $display("FAIL random_event[%0d.%0d]: got %h want %h", r, i, obs_q[i], exp_q[i]);
                    n_errors++;
                end
            end
            exp_q.delete();
        end
    endtask

    initial begin
        n_checks = 0; n_errors = 0; cyc = 0; strobe_cyc = 0; rise_cyc = 0;
        par_pulses = 0; frm_pulses = 0; prev_valid = 1'b0;
        rst_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; evif.ev_ready = 1'b0;
        test_reset();
        test_glitch_latency();
        test_prefixes();
        test_parity();
        test_timeout();
        test_overflow();
        test_typematic();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
